// File: rtl/swap_seq_if.sv
// Bundle between the SWP sequencer, the control unit, the register file and the swap store.
// The master side is the sequencer; the slave side is everything around it.
interface swap_seq_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
) ();
    logic          start;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] swp_a;
    logic [DW-1:0] swp_b;
    logic [AW-1:0] rf_rd_a;
    logic [AW-1:0] rf_rd_b;
    logic          swp_we;
    logic          rf_we;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic          busy;
    logic          done;

    modport master (
        input  start, ra, rb, swp_a, swp_b,
        output rf_rd_a, rf_rd_b, swp_we, rf_we, rf_wr_addr, rf_wr_data, busy, done
    );

    modport slave (
        output start, ra, rb, swp_a, swp_b,
        input  rf_rd_a, rf_rd_b, swp_we, rf_we, rf_wr_addr, rf_wr_data, busy, done
    );
endinterface

// File: rtl/swap_seq.sv
// SWP instruction sequencer: reads Ra/Rb into the swap store, then writes them back crossed over.
// Every output is a flop loaded from the decode of the state the FSM is leaving, so swp_we is glitch-free.
module swap_seq #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 4,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic        clk,
    input  logic        rst_f,
    swap_seq_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_WRA   = 3'd3,
        S_WRB   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ra_q, rb_q, ra_d, rb_d;

    logic [AW-1:0] rd_a_d, rd_b_d, wr_addr_d;
    logic [DW-1:0] wr_data_d;
    logic          swp_we_d, rf_we_d, busy_d, done_d;

    // Next-state and next-output decode
    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rd_a_d    = '0;
        rd_b_d    = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        swp_we_d  = 1'b0;
        rf_we_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.ra != bus.rb) begin
                        ra_d    = bus.ra;
                        rb_d    = bus.rb;
                        state_d = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                rd_a_d  = ra_q;
                rd_b_d  = rb_q;
                busy_d  = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                rd_a_d   = ra_q;
                rd_b_d   = rb_q;
                busy_d   = 1'b1;
                swp_we_d = 1'b1;
                state_d  = S_WRA;
            end
            S_WRA: begin
                rd_a_d    = ra_q;
                rd_b_d    = rb_q;
                busy_d    = 1'b1;
                rf_we_d   = (ZERO_REG == 1'b0) || (ra_q != '0);
                wr_addr_d = ra_q;
                wr_data_d = bus.swp_b;
                state_d   = S_WRB;
            end
            S_WRB: begin
                rd_a_d    = ra_q;
                rd_b_d    = rb_q;
                busy_d    = 1'b1;
                rf_we_d   = (ZERO_REG == 1'b0) || (rb_q != '0);
                wr_addr_d = rb_q;
                wr_data_d = bus.swp_a;
                state_d   = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, captured operands and output flops
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q        <= S_IDLE;
            ra_q           <= '0;
            rb_q           <= '0;
            bus.rf_rd_a    <= '0;
            bus.rf_rd_b    <= '0;
            bus.swp_we     <= 1'b0;
            bus.rf_we      <= 1'b0;
            bus.rf_wr_addr <= '0;
            bus.rf_wr_data <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            state_q        <= state_d;
            ra_q           <= ra_d;
            rb_q           <= rb_d;
            bus.rf_rd_a    <= rd_a_d;
            bus.rf_rd_b    <= rd_b_d;
            bus.swp_we     <= swp_we_d;
            bus.rf_we      <= rf_we_d;
            bus.rf_wr_addr <= wr_addr_d;
            bus.rf_wr_data <= wr_data_d;
            bus.busy       <= busy_d;
            bus.done       <= done_d;
        end
    end
endmodule
